// File: rtl/pipe_pkg.sv
// Shared pipe parameters and scheduler state encoding.
// Used by pipe_sched, rr_arbiter and the pipe FIFO.
package pipe_pkg;

    localparam int DATA_W     = 18;
    localparam int NUM_REQ    = 4;
    localparam int BURST_MAX  = 4;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
// Search starts at ptr and wraps; ptr must be below N.
module rr_arbiter
    import pipe_pkg::*;
#(
    parameter int N  = NUM_REQ,
    parameter int PW = ptr_w(NUM_REQ)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    logic [2*N-1:0] rot;
    logic [2*N-1:0] pick;
    logic [2*N-1:0] spin;
    logic           found;

    // Rotate so ptr sits at bit 0, take the lowest hit, rotate back.
    always_comb begin
        rot   = {req, req} >> ptr;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !found) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        spin = pick << ptr;
        win  = spin[N-1:0] | spin[2*N-1:N];
    end

endmodule

// File: rtl/pipe_sched.sv
// Write-side burst scheduler and read strobe for the pipe FIFO.
// Define PIPE_SCHED_PRIO_EN to give requester 0 fixed priority.
module pipe_sched
    import pipe_pkg::sched_state_e;
    import pipe_pkg::IDLE;
    import pipe_pkg::XFER;
    import pipe_pkg::ptr_w;
#(
    parameter int NUM_REQ   = pipe_pkg::NUM_REQ,
    parameter int DATA_W    = pipe_pkg::DATA_W,
    parameter int BURST_MAX = pipe_pkg::BURST_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    input  logic                      fifo_empty,
    input  logic                      comp_ready,
    output logic                      fifo_rd_en,
    output logic                      busy
);

    localparam int         PW        = ptr_w(NUM_REQ);
    localparam logic [2:0] BURST_LIM = 3'(BURST_MAX);

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] arb_win, win;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner, ptr_inc;
    logic [2:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  sel_data;
    logic               own_req, xfer, last;
    logic               rd_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .win (arb_win)
    );

`ifdef PIPE_SCHED_PRIO_EN
    assign win = req[0] ? NUM_REQ'(1) : arb_win;
`else
    assign win = arb_win;
`endif

    always_comb begin
        owner    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                owner    = PW'(i);
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign own_req = |(gnt_q & req);
    assign xfer    = (state_q == XFER) && own_req && !fifo_full;
    assign last    = xfer && ((cnt_q + 3'd1) == BURST_LIM);
    assign ptr_inc = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = XFER;
                    gnt_d   = win;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (xfer) cnt_d = cnt_q + 3'd1;
                // Full FIFO only stalls; a dropped owner req or a full burst ends it.
                if (!own_req || last) begin
                    state_d = IDLE;
                    gnt_d   = '0;
`ifdef PIPE_SCHED_PRIO_EN
                    if (!gnt_q[0]) ptr_d = ptr_inc;
`else
                    ptr_d = ptr_inc;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= 1'b0;
        else        rd_q <= comp_ready && !fifo_empty;
    end

    assign gnt          = gnt_q;
    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = xfer ? sel_data : '0;
    assign fifo_rd_en   = rd_q;
    assign busy         = (state_q == XFER);

endmodule

// File: tb/tb_pipe_sched.sv
// Randomized bench for pipe_sched against a burst-level model.
// Honours PIPE_SCHED_PRIO_EN the same way as the design.
module tb_pipe_sched;
    import pipe_pkg::*;

    localparam int N = NUM_REQ;
    localparam int W = DATA_W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic           fifo_empty;
    logic           comp_ready;
    logic           fifo_rd_en;
    logic           busy;
    logic [W-1:0]   dat [N];

    int n_chk = 0;
    int n_err = 0;

    // Reference state: burst owner (-1 when idle), words sent, next search start.
    int m_own = -1;
    int m_cnt = 0;
    int m_ptr = 0;
    int m_rd  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
    end

    pipe_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_empty   (fifo_empty),
        .comp_ready   (comp_ready),
        .fifo_rd_en   (fifo_rd_en),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner();
`ifdef PIPE_SCHED_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic end_burst();
`ifdef PIPE_SCHED_PRIO_EN
        if (m_own != 0) m_ptr = (m_own + 1) % N;
`else
        m_ptr = (m_own + 1) % N;
`endif
        m_own = -1;
    endtask

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        m_rd  = 0;
    endtask

    // Compare outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        logic [N-1:0] e_gnt;
        logic         e_wr;
        logic [W-1:0] e_dat;
        #1;
        e_gnt = (m_own < 0) ? '0 : N'(1) << m_own;
        e_wr  = (m_own >= 0) && rst_n && req[m_own] && !fifo_full;
        e_dat = e_wr ? dat[m_own] : '0;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("wr_en", 32'(fifo_wr_en), 32'(e_wr));
        check("wr_data", 32'(fifo_wr_data), 32'(e_dat));
        check("busy", 32'(busy), 32'(m_own >= 0));
        check("rd_en", 32'(fifo_rd_en), 32'(m_rd));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rd = (comp_ready && !fifo_empty) ? 1 : 0;
            if (m_own < 0) begin
                if (req != '0) begin
                    m_own = pick_winner();
                    m_cnt = 0;
                end
            end else if (!req[m_own]) begin
                end_burst();
            end else if (!fifo_full) begin
                m_cnt++;
                if (m_cnt == BURST_MAX) end_burst();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        comp_ready = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = W'(32'h100 * (i + 1) + i);
        model_reset();
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two requesters from reset: 1 bursts, bubble, then 2.
        req = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) check("d_gnt_c0", 32'(gnt), 32'h0);
            if (c == 1) check("d_gnt_c1", 32'(gnt), 32'b0010);
            if (c == 4) check("d_wr_c4", 32'(fifo_wr_en), 32'h1);
            if (c == 5) check("d_bubble", 32'(gnt), 32'h0);
            if (c == 5) check("d_bub_wr", 32'(fifo_wr_en), 32'h0);
            if (c == 6) check("d_gnt_c6", 32'(gnt), 32'b0100);
            #1;
            step();
        end
        req = '0;
        repeat (6) step();

        // Random traffic, stalls, read handshakes and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if (!rst_n) model_reset();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                if (!req[i]) dat[i] = W'($urandom);
            end
            fifo_full  = ($urandom_range(0, 3) == 0);
            fifo_empty = ($urandom_range(0, 2) == 0);
            comp_ready = ($urandom_range(0, 1) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing the 18-bit pipe FIFO.
REQ-002 Parameter DATA_W, default 18: word width.
REQ-003 Parameter BURST_MAX, default 4: maximum words accepted per grant.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request; each requester holds its data stable while its request is asserted.
REQ-007 req_data  input  NUM_REQ*DATA_W  packed requester words; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  NUM_REQ  registered one-hot grant; all zero when no requester owns the FIFO.
REQ-009 fifo_full  input  1  FIFO full flag.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_wr_data  output  DATA_W  FIFO write word.
REQ-012 fifo_empty  input  1  FIFO empty flag.
REQ-013 comp_ready  input  1  compute stage can accept one word this cycle.
REQ-014 fifo_rd_en  output  1  registered FIFO read strobe (drives the FIFO comp input).
REQ-015 busy  output  1  high when the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have two states: IDLE and XFER.
REQ-017 In IDLE with any req bit high, the block SHALL select a winner by round-robin, starting at pointer rr_ptr, then register gnt = one-hot(winner) and enter XFER; req-to-gnt latency is 1 cycle.
REQ-018 In IDLE with req all zero, the block SHALL keep gnt = 0 and remain in IDLE.
REQ-019 A word SHALL transfer in any XFER cycle where gnt[i] & req[i] & !fifo_full; fifo_wr_en is combinational from that term, and fifo_wr_data = req_data slice i, or 0 when fifo_wr_en is low.
REQ-020 A 3-bit burst counter SHALL increment on each transfer and clear on entry to XFER.
REQ-021 The burst SHALL end when the counter reaches BURST_MAX, or when req[owner] is low in XFER; the FSM then returns to IDLE, gnt clears on the next edge, and rr_ptr = owner+1 modulo NUM_REQ.
REQ-022 When fifo_full is high in XFER, the block SHALL suppress the write, hold the counter, hold gnt and stay in XFER; a full FIFO never ends a burst.
REQ-023 Each burst SHALL be followed by exactly one IDLE bubble cycle with gnt = 0 before the next grant.
REQ-024 A req bit that drops mid-burst for a non-owner SHALL have no effect; a new req that arrives mid-burst SHALL wait for the next IDLE arbitration.
REQ-025 fifo_rd_en SHALL be registered as comp_ready & !fifo_empty, giving at most one read per cycle and a 1-cycle latency from inputs.
REQ-026 The read path SHALL be independent of the write FSM; simultaneous read and write in the same cycle SHALL be allowed.

Reset
REQ-027 While rst_n is low, the block SHALL immediately hold state = IDLE, gnt = 0, rr_ptr = 0, burst counter = 0 and fifo_rd_en = 0; fifo_wr_en and busy are therefore 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further write; after rst_n rises, arbitration restarts from requester 0.

Configuration
REQ-029 With PIPE_SCHED_PRIO_EN defined, a requester-0 request seen in IDLE SHALL win regardless of rr_ptr, and rr_ptr SHALL not advance after a requester-0 burst.
REQ-030 Without PIPE_SCHED_PRIO_EN, all requesters SHALL be pure round-robin.

Structure
REQ-031 Package pipe_pkg SHALL hold DATA_W, NUM_REQ, BURST_MAX, FIFO_DEPTH (8) and the FSM state enum; these are shared with the pipe FIFO.
REQ-032 The winner selection SHALL be the sub-module rr_arbiter (inputs req and ptr; output one-hot winner), combinational only.

Verification
REQ-033 req = 4'b0110 from reset, no full -> gnt = 4'b0010 for 4 writes, bubble, then gnt = 4'b0100 for 4 writes; rr_ptr = 3.
REQ-034 req[2] held for 2 words then dropped -> 2 fifo_wr_en pulses, gnt clears, next winner starts searching at requester 3.
REQ-035 fifo_full high for 3 cycles mid-burst after word 1 -> no writes during those cycles, gnt held, 4 total words after fifo_full falls, data order preserved.
REQ-036 rst_n pulsed low during word 2 of a requester-1 burst -> gnt = 0 and fifo_wr_en = 0 immediately, rr_ptr = 0; the next grant goes to the lowest active index.
REQ-037 comp_ready = 1 with the FIFO loaded with 8 words -> 8 consecutive fifo_rd_en pulses starting 1 cycle later, and fifo_rd_en drops the cycle after fifo_empty rises.
REQ-038 With PIPE_SCHED_PRIO_EN defined, req = 4'b1001 persistently -> requester 0 wins every arbitration; without the macro, the grants alternate 0, 3, 0, 3.
